// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: active-low segment codes
// ({dp,g,f,e,d,c,b,a}), the converter state type and the BCD-to-segment decoder.
package seg_pkg;

    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    // Sequential double-dabble converter states
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCheck
    } conv_state_e;

    // Map one BCD digit to its active-low segment pattern (dp off); non-decimal codes go dark
    function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
        logic [7:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Value-input channel of seg_scan_ctrl: binary value plus decimal-point mask, valid/ready.
// The source side uses the master modport, the display block the slave modport.
interface seg_scan_ctrl_if #(
    parameter int unsigned DW   = 20,
    parameter int unsigned NDIG = 6
);

    logic [DW-1:0]   din;
    logic            din_vld;
    logic            din_rdy;
    logic [NDIG-1:0] dp_mask;

    modport master (
        output din,
        output din_vld,
        output dp_mask,
        input  din_rdy
    );

    modport slave (
        input  din,
        input  din_vld,
        input  dp_mask,
        output din_rdy
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One add-3/shift step per cycle for DW cycles, then one check cycle in which done is high and
// bcd/ovf are final. ovf flags values that need more than NDIG decimal digits: any bit shifted
// out of the top BCD digit is a decimal carry beyond the register.
module bin2bcd_seq import seg_pkg::*; #(
    parameter int unsigned DW   = 20,
    parameter int unsigned NDIG = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DW-1:0]     bin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] bcd,
    output logic              ovf
);

    localparam int unsigned CW = $clog2(DW + 1);
    localparam int unsigned BW = 4 * NDIG;

    conv_state_e   state_q, state_d;
    logic [DW-1:0] bin_q, bin_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [BW-1:0]    adj;
    logic [BW+DW:0]   sh;

    // One double-dabble step: add 3 to every digit >= 5, then shift {carry, bcd, bin} left
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        sh = {1'b0, adj, bin_q} << 1;
    end

    // Next-state: load on start, DW shift steps, then a single check/done cycle
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bin_d   = bin;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                bin_d = sh[DW-1:0];
                bcd_d = sh[BW+DW-1:DW];
                ovf_d = ovf_q | sh[BW+DW];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StCheck);
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// N-digit multiplexed seven-segment driver (common anode, active-low sel and segments).
// Accepts a binary value over a valid/ready channel, converts it to BCD, parks the result in a
// pending register and swaps it into the display only at a frame boundary, so a frame never mixes
// old and new digits. Adds leading-zero blanking, per-digit decimal points and overflow dashes.
// Optional feature macro SEG_DIM_EN: adds the bright[3:0] port for per-slot PWM dimming.
module seg_scan_ctrl import seg_pkg::*; #(
    parameter int unsigned NDIG      = 6,
    parameter int unsigned DW        = 20,   // 2**DW must be >= 10**NDIG
    parameter int unsigned TIME_SCAN = 1000
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus,
`ifdef SEG_DIM_EN
    input  logic [3:0]      bright,
`endif
    input  logic            blank_en,
    output logic [NDIG-1:0] sel,
    output logic [7:0]      dig,
    output logic            frame_tick
);

    localparam int unsigned SW = $clog2(TIME_SCAN + 1);
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned BW = 4 * NDIG;

    // Converter hookup
    logic          accept;
    logic          conv_busy;
    logic          conv_done;
    logic [BW-1:0] conv_bcd;
    logic          conv_ovf;

    // Handshake capture, pending and display registers
    logic [NDIG-1:0] dp_cap_q, dp_cap_d;
    logic [BW-1:0]   pend_bcd_q, pend_bcd_d;
    logic            pend_ovf_q, pend_ovf_d;
    logic [NDIG-1:0] pend_dp_q, pend_dp_d;
    logic            pend_vld_q, pend_vld_d;
    logic [BW-1:0]   disp_bcd_q, disp_bcd_d;
    logic            disp_ovf_q, disp_ovf_d;
    logic [NDIG-1:0] disp_dp_q, disp_dp_d;

    // Scan timing
    logic [SW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          slot_end;
    logic          wrap;

    // Output registers
    logic [NDIG-1:0] sel_q, sel_d;
    logic [7:0]      dig_q, dig_d;

    // Output decode helpers
    logic [IW-1:0] msd;
    logic [3:0]    cur_bcd;
    logic          blank;
    logic          lit;

`ifdef SEG_DIM_EN
    logic [3:0] bright_q, bright_d;
`endif

    assign accept      = bus.din_vld & ~conv_busy;
    assign bus.din_rdy = ~conv_busy;

    bin2bcd_seq #(
        .DW   (DW),
        .NDIG (NDIG)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .bin   (bus.din),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    // Slot counter and digit index; wrap marks the frame boundary
    always_comb begin
        slot_end = (cnt_q == SW'(TIME_SCAN - 1));
        wrap     = slot_end && (idx_q == IW'(NDIG - 1));
        cnt_d    = slot_end ? '0 : cnt_q + SW'(1);
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end
    end

    // Capture dp with the value, park converter results, swap into display at a boundary
    always_comb begin
        dp_cap_d   = dp_cap_q;
        pend_bcd_d = pend_bcd_q;
        pend_ovf_d = pend_ovf_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        disp_bcd_d = disp_bcd_q;
        disp_ovf_d = disp_ovf_q;
        disp_dp_d  = disp_dp_q;

        if (accept) begin
            dp_cap_d = bus.dp_mask;
        end
        // Only a pending value already registered before this cycle is displayed
        if (wrap && pend_vld_q) begin
            disp_bcd_d = pend_bcd_q;
            disp_ovf_d = pend_ovf_q;
            disp_dp_d  = pend_dp_q;
            pend_vld_d = 1'b0;
        end
        // A completion on the boundary cycle stays pending for the next boundary
        if (conv_done) begin
            pend_bcd_d = conv_bcd;
            pend_ovf_d = conv_ovf;
            pend_dp_d  = dp_cap_q;
            pend_vld_d = 1'b1;
        end
    end

    // Segment pattern and digit enable for the digit currently indexed
    always_comb begin
        msd = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (disp_bcd_q[4*i +: 4] != 4'd0) begin
                msd = IW'(i);
            end
        end
        cur_bcd = disp_bcd_q[4*idx_q +: 4];
        // idx_q > msd already excludes digit 0
        blank   = blank_en && !disp_ovf_q && (idx_q > msd);
`ifdef SEG_DIM_EN
        lit     = (32'(cnt_q) < (((32'(bright_q) + 32'd1) * TIME_SCAN) / 32'd16));
        bright_d = slot_end ? bright : bright_q;
`else
        lit     = 1'b1;
`endif

        sel_d = ~(NDIG'(1) << idx_q);
        if (disp_ovf_q) begin
            dig_d = SEG_DASH;
        end else begin
            dig_d = blank ? SEG_OFF : seg_decode(cur_bcd);
            if (disp_dp_q[idx_q]) begin
                dig_d[7] = 1'b0;
            end
        end
        if (!lit) begin
            sel_d = '1;
            dig_d = SEG_OFF;
        end
    end

    // All state registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_cap_q   <= '0;
            pend_bcd_q <= '0;
            pend_ovf_q <= 1'b0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            disp_bcd_q <= '0;
            disp_ovf_q <= 1'b0;
            disp_dp_q  <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            sel_q      <= '1;
            dig_q      <= SEG_OFF;
`ifdef SEG_DIM_EN
            bright_q   <= 4'hF;
`endif
        end else begin
            dp_cap_q   <= dp_cap_d;
            pend_bcd_q <= pend_bcd_d;
            pend_ovf_q <= pend_ovf_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            disp_bcd_q <= disp_bcd_d;
            disp_ovf_q <= disp_ovf_d;
            disp_dp_q  <= disp_dp_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            dig_q      <= dig_d;
`ifdef SEG_DIM_EN
            bright_q   <= bright_d;
`endif
        end
    end

    assign sel        = sel_q;
    assign dig        = dig_q;
    assign frame_tick = wrap;

endmodule
